// File: rtl/bcd_adder_if.sv
// bcd_adder_if: operand/result bundle for the registered BCD adder.
// Ports: in_valid,a,b,cin (requester->adder); sum,cout,out_valid,err (adder->requester).
interface bcd_adder_if #(
    parameter int DIGITS = 1
);
    logic                  in_valid;
    logic [4*DIGITS-1:0]   a;
    logic [4*DIGITS-1:0]   b;
    logic                  cin;
    logic [4*DIGITS-1:0]   sum;
    logic                  cout;
    logic                  out_valid;
    logic                  err;

    modport master (
        output in_valid, a, b, cin,
        input  sum, cout, out_valid, err
    );

    modport slave (
        input  in_valid, a, b, cin,
        output sum, cout, out_valid, err
    );
endinterface

// File: rtl/bcd_adder.sv
// bcd_adder: registered multi-digit 8421 BCD adder, one op per cycle.
// Ports: clk, rst_n (sync, active-low), bus (slave: in_valid/a/b/cin -> sum/cout/out_valid/err).
module bcd_adder #(
    parameter int DIGITS = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    bcd_adder_if.slave  bus
);
    localparam int W = 4 * DIGITS;

    logic [W-1:0] sum_n;
    logic         cout_n;
    logic         err_n;
    logic [4:0]   s;
    logic         c;

    logic [W-1:0] sum_q;
    logic         cout_q;
    logic         err_q;
    logic         vld_q;

    // Digit-serial ripple. Out-of-range digits go through the same
    // correction; the +6 wraps mod 16 by truncation to 4 bits.
    always_comb begin
        sum_n = '0;
        err_n = 1'b0;
        s     = '0;
        c     = bus.cin;
        for (int i = 0; i < DIGITS; i++) begin
            s = {1'b0, bus.a[4*i +: 4]}
              + {1'b0, bus.b[4*i +: 4]}
              + {4'b0, c};
            if (s > 5'd9) begin
                sum_n[4*i +: 4] = s[3:0] + 4'd6;
                c = 1'b1;
            end else begin
                sum_n[4*i +: 4] = s[3:0];
                c = 1'b0;
            end
            err_n = err_n
                  | (bus.a[4*i +: 4] > 4'd9)
                  | (bus.b[4*i +: 4] > 4'd9);
        end
        cout_n = c;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            err_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else if (bus.in_valid) begin
            sum_q  <= sum_n;
            cout_q <= cout_n;
            err_q  <= err_n;
            vld_q  <= 1'b1;
        end else begin
            vld_q  <= 1'b0;
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.err       = err_q;
    assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_bcd_adder.sv
// tb_bcd_adder: table-driven + scoreboard bench for bcd_adder.
// Exercises a 1-digit and a 4-digit instance side by side.
module tb_bcd_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    bcd_adder_if #(.DIGITS(1)) if1 ();
    bcd_adder_if #(.DIGITS(4)) if4 ();

    bcd_adder #(.DIGITS(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    bcd_adder #(.DIGITS(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    typedef struct {
        logic        v;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        co;
        logic        e;
    } vec_t;

    vec_t q1[$];
    vec_t q4[$];
    vec_t last1;
    vec_t last4;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check(input bit w, input logic ev, input logic ov,
                         input logic [15:0] s, input logic co,
                         input logic e);
        vec_t x;
        string p;
        p = w ? "d4" : "d1";
        chk({p, "_out_valid"}, {31'b0, ov}, {31'b0, ev});
        if (ev) begin
            if ((w && q4.size() == 0) || (!w && q1.size() == 0)) begin
                n_tests++;
                n_fail++;
                $display("FAIL %s_scoreboard: got result, expected none", p);
                return;
            end
            if (w) begin
                x = q4.pop_front();
                last4 = x;
            end else begin
                x = q1.pop_front();
                last1 = x;
            end
        end
        x = w ? last4 : last1;
        chk({p, "_sum"},  {16'b0, s},  {16'b0, x.s});
        chk({p, "_cout"}, {31'b0, co}, {31'b0, x.co});
        chk({p, "_err"},  {31'b0, e},  {31'b0, x.e});
    endtask

    task automatic drive(input bit w, input vec_t t);
        if (w) begin
            if4.in_valid = t.v;
            if4.a = t.a;
            if4.b = t.b;
            if4.cin = t.cin;
            if (t.v) q4.push_back(t);
        end else begin
            if1.in_valid = t.v;
            if1.a = t.a[3:0];
            if1.b = t.b[3:0];
            if1.cin = t.cin;
            if (t.v) q1.push_back(t);
        end
        @(posedge clk);
        #1;
        if (w)
            check(1'b1, t.v, if4.out_valid, if4.sum, if4.cout, if4.err);
        else
            check(1'b0, t.v, if1.out_valid, {12'h0, if1.sum},
                  if1.cout, if1.err);
    endtask

    task automatic chk_zero();
        chk("rst_d1_sum", {28'b0, if1.sum}, 32'h0);
        chk("rst_d1_cout", {31'b0, if1.cout}, 32'h0);
        chk("rst_d1_valid", {31'b0, if1.out_valid}, 32'h0);
        chk("rst_d1_err", {31'b0, if1.err}, 32'h0);
        chk("rst_d4_sum", {16'b0, if4.sum}, 32'h0);
        chk("rst_d4_cout", {31'b0, if4.cout}, 32'h0);
        chk("rst_d4_valid", {31'b0, if4.out_valid}, 32'h0);
        chk("rst_d4_err", {31'b0, if4.err}, 32'h0);
    endtask

    function automatic int from_bcd(input logic [15:0] x);
        int r = 0;
        for (int i = 3; i >= 0; i--) r = r * 10 + int'(x[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        int m = n;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    vec_t t1[14];
    vec_t t4[8];

    initial begin
        // 1-digit vectors: {v, a, b, cin, sum, cout, err}
        t1[0]  = '{1, 16'h9, 16'h9, 1, 16'h9, 1, 0};
        t1[1]  = '{1, 16'h6, 16'h3, 0, 16'h9, 0, 0};
        t1[2]  = '{1, 16'h7, 16'h5, 0, 16'h2, 1, 0};
        t1[3]  = '{1, 16'h8, 16'h4, 0, 16'h2, 1, 0};
        t1[4]  = '{1, 16'h9, 16'h9, 0, 16'h8, 1, 0};
        t1[5]  = '{1, 16'h5, 16'h6, 1, 16'h2, 1, 0};
        t1[6]  = '{1, 16'hA, 16'h5, 0, 16'h5, 1, 1};
        t1[7]  = '{0, 16'h1, 16'h1, 0, 16'h0, 0, 0};
        t1[8]  = '{0, 16'h2, 16'h2, 1, 16'h0, 0, 0};
        t1[9]  = '{1, 16'h0, 16'h0, 0, 16'h0, 0, 0};
        t1[10] = '{1, 16'h0, 16'h0, 1, 16'h1, 0, 0};
        t1[11] = '{1, 16'hF, 16'hF, 1, 16'h5, 1, 1};
        t1[12] = '{1, 16'h3, 16'hA, 0, 16'h3, 1, 1};
        t1[13] = '{1, 16'h4, 16'h5, 0, 16'h9, 0, 0};

        t4[0] = '{1, 16'h9999, 16'h0000, 1, 16'h0000, 1, 0};
        t4[1] = '{1, 16'h1234, 16'h5678, 0, 16'h6912, 0, 0};
        t4[2] = '{1, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0};
        t4[3] = '{1, 16'h9999, 16'h9999, 1, 16'h9999, 1, 0};
        t4[4] = '{1, 16'h0999, 16'h0001, 0, 16'h1000, 0, 0};
        t4[5] = '{1, 16'h4999, 16'h5000, 1, 16'h0000, 1, 0};
        t4[6] = '{1, 16'h0A00, 16'h0000, 0, 16'h1000, 0, 1};
        t4[7] = '{0, 16'h1111, 16'h2222, 0, 16'h0000, 0, 0};

        last1 = '{default: '0};
        last4 = '{default: '0};

        // Reset held with valid operands: op dropped, outputs cleared.
        if1.in_valid = 1'b1; if1.a = 4'h9; if1.b = 4'h9; if1.cin = 1'b0;
        if4.in_valid = 1'b1; if4.a = 16'h9999; if4.b = 16'h9999;
        if4.cin = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk_zero();
        end
        if4.in_valid = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) drive(1'b0, t1[i]);

        // Reset wins over a simultaneous valid op.
        rst_n = 1'b0;
        if1.in_valid = 1'b1; if1.a = 4'h8; if1.b = 4'h7; if1.cin = 1'b1;
        @(posedge clk);
        #1;
        chk_zero();
        rst_n = 1'b1;
        if1.in_valid = 1'b0;
        last1 = '{default: '0};

        for (int i = 0; i < 8; i++) drive(1'b1, t4[i]);

        // Random legal 4-digit operands against a decimal reference.
        for (int i = 0; i < 20; i++) begin
            vec_t t;
            int sm;
            t.v = 1'b1;
            for (int d = 0; d < 4; d++) begin
                t.a[4*d +: 4] = 4'($urandom_range(0, 9));
                t.b[4*d +: 4] = 4'($urandom_range(0, 9));
            end
            t.cin = 1'($urandom_range(0, 1));
            sm = from_bcd(t.a) + from_bcd(t.b) + int'(t.cin);
            t.s = to_bcd(sm % 10000);
            t.co = (sm >= 10000);
            t.e = 1'b0;
            drive(1'b1, t);
        end
        drive(1'b1, t4[7]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
